// File: rtl/jacobi_matvec.sv
// Sequential fixed-point y = A*x using one shared multiplier and one MAC per clock; start may restart at any time.
// Latency SIZE*SIZE+1 cycles from start to ready; no backpressure, y/ready hold in IDLE until the next start.
module jacobi_matvec #(
  parameter int SIZE      = 3,
  parameter int PRECISION = 16,
  parameter int POINT     = 8,
  localparam int W        = PRECISION + POINT
) (
  input  logic                clk,
  input  logic                I_RST,
  input  logic signed [W-1:0] A [SIZE][SIZE],
  input  logic signed [W-1:0] x [SIZE],
  input  logic                start,
  output logic signed [W-1:0] y [SIZE],
  output logic                busy,
  output logic                ready
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int RW = $clog2(SIZE + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(SIZE - 1);
  localparam logic [RW-1:0] ROW_DONE = RW'(SIZE);

  typedef enum logic {IDLE, MAC} state_t;

  state_t                state;
  logic [RW-1:0]         row;
  logic [CW-1:0]         col;
  logic [CW-1:0]         row_idx;
  logic signed [W-1:0]   acc;
  logic signed [W-1:0]   term;
  logic signed [W-1:0]   sum;
  logic signed [W-1:0]   work [SIZE];
  logic signed [2*W-1:0] a_ext;
  logic signed [2*W-1:0] x_ext;
  logic signed [2*W-1:0] prod;

  // row == SIZE is the extra commit cycle; clamp the index so A is never read out of range
  always_comb begin
    row_idx = (row == ROW_DONE) ? '0 : row[CW-1:0];
    a_ext   = (2*W)'(A[row_idx][col]);
    x_ext   = (2*W)'(x[col]);
    prod    = a_ext * x_ext;
    term    = W'(prod >>> POINT);
    sum     = acc + term;
  end

  always_ff @(posedge clk) begin
    if (I_RST) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      acc   <= '0;
      ready <= 1'b0;
      busy  <= 1'b0;
      for (int k = 0; k < SIZE; k++) begin
        y[k]    <= '0;
        work[k] <= '0;
      end
    end else if (start) begin
      state <= MAC;
      row   <= '0;
      col   <= '0;
      acc   <= '0;
      ready <= 1'b0;
      busy  <= 1'b1;
    end else if (state == MAC) begin
      if (row == ROW_DONE) begin
        // all rows publish together so y never exposes a partial result
        for (int k = 0; k < SIZE; k++) y[k] <= work[k];
        ready <= 1'b1;
        busy  <= 1'b0;
        state <= IDLE;
        row   <= '0;
      end else if (col == COL_LAST) begin
        work[row_idx] <= sum;
        acc           <= '0;
        col           <= '0;
        row           <= row + 1'b1;
      end else begin
        acc <= sum;
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jacobi_matvec.sv
// Bench for jacobi_matvec: directed cases plus random matrices, scoreboard fed by the driver, checked by a monitor.
module tb_jacobi_matvec;
  localparam int SIZE = 3;
  localparam int PRECISION = 16;
  localparam int POINT = 8;
  localparam int W = PRECISION + POINT;

  logic clk = 1'b0;
  logic I_RST = 1'b1;
  logic start = 1'b0;
  logic signed [W-1:0] A [SIZE][SIZE];
  logic signed [W-1:0] x [SIZE];
  logic signed [W-1:0] y [SIZE];
  logic busy;
  logic ready;

  typedef logic [SIZE-1:0][W-1:0] vec_t;
  typedef struct packed {
    vec_t        y;
    logic [31:0] due;
  } exp_t;

  exp_t sb[$];
  vec_t shown_y = '0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic ready_q = 1'b0;

  jacobi_matvec #(.SIZE(SIZE), .PRECISION(PRECISION), .POINT(POINT)) dut (
    .clk(clk), .I_RST(I_RST), .A(A), .x(x), .start(start),
    .y(y), .busy(busy), .ready(ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: each term is floor(A*x / 2^POINT), row sums wrap modulo 2^W
  function automatic vec_t model();
    vec_t r;
    for (int i = 0; i < SIZE; i++) begin
      longint s;
      s = 0;
      for (int j = 0; j < SIZE; j++) begin
        longint p;
        longint f;
        p = longint'(A[i][j]) * longint'(x[j]);
        f = p / 256;
        if (p < 0 && (p % 256) != 0) f = f - 1;
        s = s + f;
      end
      r[i] = W'(s);
    end
    return r;
  endfunction

  task automatic clear_all();
    for (int i = 0; i < SIZE; i++) begin
      x[i] = '0;
      for (int j = 0; j < SIZE; j++) A[i][j] = '0;
    end
  endtask

  task automatic load_tridiag();
    clear_all();
    A[0][0] = 1024; A[0][1] = 256;
    A[1][0] = 256;  A[1][1] = 1024; A[1][2] = 256;
    A[2][1] = 256;  A[2][2] = 1024;
    x[0] = 256; x[1] = 512; x[2] = 768;
  endtask

  // Called at posedge+1; start is sampled on the following edge, result due 10 edges after that
  task automatic issue(input bit restart);
    exp_t e;
    if (restart && sb.size() != 0) void'(sb.pop_back());
    e.y = model();
    e.due = 32'(cyc + 11);
    sb.push_back(e);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s timeout: %0d results pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_y(input string name, input int e0, input int e1, input int e2);
    n_cmp++;
    if (y[0] !== W'(e0) || y[1] !== W'(e1) || y[2] !== W'(e2) || ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s: y={%0d,%0d,%0d} ready=%b, required y={%0d,%0d,%0d} ready=1",
               name, y[0], y[1], y[2], ready, e0, e1, e2);
    end
  endtask

  task automatic check_reset_state(input string name);
    n_cmp++;
    if (y[0] !== '0 || y[1] !== '0 || y[2] !== '0 || busy !== 1'b0 || ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s: y={%0d,%0d,%0d} busy=%b ready=%b, required all zero",
               name, y[0], y[1], y[2], busy, ready);
    end
  endtask

  // Monitor: result on each ready rise, otherwise y must hold its last published value
  always @(negedge clk) begin
    vec_t yc;
    exp_t e;
    for (int k = 0; k < SIZE; k++) yc[k] = y[k];
    if (ready === 1'b1 && ready_q !== 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_ready at cycle %0d: y=%h, required no result", cyc, yc);
      end else begin
        e = sb.pop_front();
        if (yc !== e.y || cyc != int'(e.due)) begin
          n_err++;
          $display("FAIL result: y=%h at cycle %0d, required y=%h at cycle %0d",
                   yc, cyc, e.y, e.due);
        end
        shown_y = e.y;
      end
    end else if (cyc > 0) begin
      n_cmp++;
      if (yc !== shown_y || (busy === 1'b1 && ready !== 1'b0)) begin
        n_err++;
        $display("FAIL hold at cycle %0d: y=%h busy=%b ready=%b, required y=%h and ready=0 while busy",
                 cyc, yc, busy, ready, shown_y);
      end
    end
    ready_q = ready;
  end

  initial begin
    bit seen;
    clear_all();
    I_RST = 1'b1;
    repeat (2) @(posedge clk);
    #1 I_RST = 1'b0;
    check_reset_state("reset_state");

    clear_all();
    A[0][0] = 256; A[1][1] = 256; A[2][2] = 256;
    x[0] = 384; x[1] = -512; x[2] = 64;
    issue(0);
    wait_done("identity");
    check_y("identity", 384, -512, 64);

    load_tridiag();
    issue(0);
    wait_done("tridiag");
    check_y("tridiag", 1536, 3072, 3584);

    clear_all();
    A[0][0] = -1; x[0] = 1;
    issue(0);
    wait_done("floor");
    check_y("floor", -1, 0, 0);

    load_tridiag();
    issue(0);
    repeat (3) @(posedge clk);
    #1;
    x[0] = 256; x[1] = 256; x[2] = 256;
    issue(1);
    wait_done("restart");
    check_y("restart", 1280, 1536, 1280);

    load_tridiag();
    issue(0);
    repeat (4) @(posedge clk);
    #1 I_RST = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 I_RST = 1'b0;
    shown_y = '0;
    check_reset_state("reset_mid_op");
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (ready !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_err++;
      $display("FAIL no_ready_after_reset: ready=1 seen, required 0 for 20 cycles");
    end

    clear_all();
    A[0][0] = 4194304; A[0][1] = 4194304; A[0][2] = 4194304;
    x[0] = 256; x[1] = 256; x[2] = 256;
    issue(0);
    wait_done("wrap");
    check_y("wrap", -4194304, 0, 0);

    for (int t = 0; t < 40; t++) begin
      bit wide;
      wide = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < SIZE; i++) begin
        x[i] = wide ? W'($urandom()) : W'(int'($urandom_range(0, 2047)) - 1024);
        for (int j = 0; j < SIZE; j++)
          A[i][j] = wide ? W'($urandom()) : W'(int'($urandom_range(0, 4095)) - 2048);
      end
      issue(0);
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 8)) @(posedge clk);
        #1;
        for (int i = 0; i < SIZE; i++) x[i] = W'($urandom());
        issue(1);
      end
      wait_done("random");
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
